// File: rtl/card_display_bank_pkg.sv
// Shared definitions for the card display bank: card codes, 7-segment
// patterns (active-low, bit 6 = segment g ... bit 0 = segment a), the blink
// FSM state type and the card/digit decode helpers.
package card_disp_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_A     = 4'd1;
    localparam card_t CARD_10    = 4'd10;
    localparam card_t CARD_J     = 4'd11;
    localparam card_t CARD_Q     = 4'd12;
    localparam card_t CARD_K     = 4'd13;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_10    = 7'b1000000;
    localparam logic [6:0] SEG_J     = 7'b1100001;
    localparam logic [6:0] SEG_Q     = 7'b0011000;
    localparam logic [6:0] SEG_K     = 7'b0001001;
    localparam logic [6:0] SEG_DIG0  = 7'b1000000;
    localparam logic [6:0] SEG_DIG1  = 7'b1111001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OFF  = 2'd1,
        ON   = 2'd2
    } blink_state_t;

    function automatic logic [6:0] card_to_seg(card_t c);
        case (c)
            CARD_A:  return SEG_A;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            CARD_10: return SEG_10;
            CARD_J:  return SEG_J;
            CARD_Q:  return SEG_Q;
            CARD_K:  return SEG_K;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Baccarat value: face cards and tens count zero.
    function automatic logic [3:0] card_value(card_t c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [6:0] digit_to_seg(logic [3:0] d);
        case (d)
            4'd0:    return SEG_DIG0;
            4'd1:    return SEG_DIG1;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                     return card_to_seg(d);
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/card_display_bank_if.sv
// Load bus from the dealer datapath into the display bank.
//   clear     : empty all slots, abort any blink
//   load_en   : write load_card into load_slot
//   load_slot : target slot index
//   load_card : card code
//   blink_en  : blink the loaded slot
interface card_display_bank_if #(
    parameter int N_SLOTS = 6
);
    import card_disp_pkg::*;

    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic              clear;
    logic              load_en;
    logic [SLOT_W-1:0] load_slot;
    card_t             load_card;
    logic              blink_en;

    modport master (output clear, load_en, load_slot, load_card, blink_en);
    modport slave  (input  clear, load_en, load_slot, load_card, blink_en);
endinterface

// File: rtl/card_display_bank_blink_fsm.sv
// Blink sequencer for the most recently dealt slot.
//   slow_clock, resetb : clock, synchronous active-low reset
//   clear              : abort sequence
//   load_valid         : in-range load this edge
//   blink_en, load_slot: blink request and its slot
//   blank_mask         : per-slot blank request (high while OFF)
//   busy               : sequence in progress
//
// state | meaning
// IDLE  | no blink, all slots steady
// OFF   | blink_slot blanked for BLINK_HALF cycles
// ON    | blink_slot lit for BLINK_HALF cycles, then next period or IDLE
module card_blink_fsm
    import card_disp_pkg::*;
#(
    parameter int N_SLOTS     = 6,
    parameter int BLINK_HALF  = 8,
    parameter int BLINK_COUNT = 3,
    localparam int SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               clear,
    input  logic               load_valid,
    input  logic               blink_en,
    input  logic [SLOT_W-1:0]  load_slot,
    output logic [N_SLOTS-1:0] blank_mask,
    output logic               busy
);
    localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int PW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    blink_state_t      state_q, state_d;
    logic [HW-1:0]     half_q, half_d;
    logic [PW-1:0]     per_q, per_d;
    logic [SLOT_W-1:0] blink_slot_q, blink_slot_d;

    logic half_done;
    assign half_done = (half_q == HW'(BLINK_HALF - 1));

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        per_d        = per_q;
        blink_slot_d = blink_slot_q;
        if (clear) begin
            state_d = IDLE;
            half_d  = '0;
            per_d   = '0;
        end else if (load_valid && blink_en) begin
            // New blinking load restarts the sequence from any state.
            state_d      = OFF;
            blink_slot_d = load_slot;
            half_d       = '0;
            per_d        = '0;
        end else begin
            case (state_q)
                OFF: begin
                    if (half_done) begin
                        state_d = ON;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
                ON: begin
                    if (half_done) begin
                        half_d = '0;
                        if (per_q == PW'(BLINK_COUNT - 1)) begin
                            state_d = IDLE;
                            per_d   = '0;
                        end else begin
                            state_d = OFF;
                            per_d   = per_q + 1'b1;
                        end
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q      <= IDLE;
            half_q       <= '0;
            per_q        <= '0;
            blink_slot_q <= '0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            per_q        <= per_d;
            blink_slot_q <= blink_slot_d;
        end
    end

    always_comb begin
        blank_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            blank_mask[i] = (state_q == OFF) && (blink_slot_q == SLOT_W'(i));
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/card_display_bank.sv
// Card display bank: N_SLOTS card registers, one 7-segment digit per slot,
// a blinking highlight on the last dealt slot and a Baccarat score digit.
//   slow_clock, resetb : clock, synchronous active-low reset
//   bus                : load bus (clear/load_en/load_slot/load_card/blink_en)
//   card_out           : stored card codes, slot i at [4i+3:4i]
//   seg7_out           : active-low segments, slot i at [7i+6:7i]
//   score_seg7         : active-low digit of hand score
//   busy               : blink sequence in progress
module card_display_bank
    import card_disp_pkg::*;
#(
    parameter int N_SLOTS     = 6,
    parameter int BLINK_HALF  = 8,
    parameter int BLINK_COUNT = 3
) (
    input  logic                   slow_clock,
    input  logic                   resetb,
    card_display_bank_if.slave     bus,
    output logic [N_SLOTS*4-1:0]   card_out,
    output logic [N_SLOTS*7-1:0]   seg7_out,
    output logic [6:0]             score_seg7,
    output logic                   busy
);
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    card_t                slot_q [N_SLOTS];
    card_t                slot_d [N_SLOTS];
    logic [N_SLOTS*7-1:0] seg_q, seg_d;
    logic [6:0]           score_seg_q, score_seg_d;
    logic [N_SLOTS-1:0]   blank_mask;
    logic                 load_valid;
    logic [4:0]           acc;

    assign load_valid = bus.load_en &&
                        ({1'b0, bus.load_slot} < (SLOT_W + 1)'(N_SLOTS));

    card_blink_fsm #(
        .N_SLOTS    (N_SLOTS),
        .BLINK_HALF (BLINK_HALF),
        .BLINK_COUNT(BLINK_COUNT)
    ) u_blink (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (bus.clear),
        .load_valid (load_valid),
        .blink_en   (bus.blink_en),
        .load_slot  (bus.load_slot),
        .blank_mask (blank_mask),
        .busy       (busy)
    );

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (bus.clear) begin
                slot_d[i] = CARD_EMPTY;
            end else if (load_valid && (bus.load_slot == SLOT_W'(i))) begin
                slot_d[i] = bus.load_card;
            end
        end
    end

    // Outputs are decoded from the current (registered) slot and FSM state,
    // so they trail the slot registers by one edge.
    always_comb begin
        seg_d = '0;
        acc   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            seg_d[7*i +: 7] = blank_mask[i] ? SEG_BLANK : card_to_seg(slot_q[i]);
            acc = acc + {1'b0, card_value(slot_q[i])};
            if (acc >= 5'd10) begin
                acc = acc - 5'd10;
            end
        end
        score_seg_d = digit_to_seg(acc[3:0]);
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_q[i] <= CARD_EMPTY;
            end
            seg_q       <= {N_SLOTS{SEG_BLANK}};
            score_seg_q <= SEG_DIG0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            seg_q       <= seg_d;
            score_seg_q <= score_seg_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            card_out[4*i +: 4] = slot_q[i];
        end
    end

    assign seg7_out   = seg_q;
    assign score_seg7 = score_seg_q;

endmodule

// File: tb/tb_card_display_bank.sv
module tb_card_display_bank;
    localparam int NS = 6;
    localparam int H  = 2;
    localparam int C  = 2;
    localparam logic [6:0] BL = 7'b1111111;

    logic            slow_clock = 1'b0;
    logic            resetb;
    logic [NS*4-1:0] card_out;
    logic [NS*7-1:0] seg7_out;
    logic [6:0]      score_seg7;
    logic            busy;

    int  checks = 0;
    int  errors = 0;
    bit  mon_on = 0;

    card_display_bank_if #(.N_SLOTS(NS)) bus ();

    card_display_bank #(
        .N_SLOTS    (NS),
        .BLINK_HALF (H),
        .BLINK_COUNT(C)
    ) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus),
        .card_out   (card_out),
        .seg7_out   (seg7_out),
        .score_seg7 (score_seg7),
        .busy       (busy)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int c);
        case (c)
            1: return 7'b0001000;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;
            5: return 7'b0010010;   6: return 7'b0000010;
            7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b1000000;
           11: return 7'b1100001;  12: return 7'b0011000;
           13: return 7'b0001001;
           default: return BL;
        endcase
    endfunction

    function automatic logic [6:0] digit(input int d);
        if (d == 0) return 7'b1000000;
        if (d == 1) return 7'b1111001;
        return glyph(d);
    endfunction

    // Behavioural model: card array, blink described by elapsed time since
    // the blinking load (OFF during even half-periods, active for 2*H*C).
    int              m_card [NS];
    bit              m_act = 0;
    int              m_slot = 0;
    int              m_el = 0;
    logic [NS*4-1:0] e_card = '0;
    logic [NS*7-1:0] e_seg = {NS{BL}};
    logic [6:0]      e_score = 7'b1000000;
    bit              e_busy = 0;

    initial for (int i = 0; i < NS; i++) m_card[i] = 0;

    always @(posedge slow_clock) begin
        int sum;
        bit valid;
        if (!resetb) begin
            for (int i = 0; i < NS; i++) m_card[i] = 0;
            m_act = 0;
            e_seg = {NS{BL}};
            e_score = 7'b1000000;
        end else begin
            sum = 0;
            for (int i = 0; i < NS; i++) begin
                if (m_act && ((m_el / H) % 2 == 0) && i == m_slot)
                    e_seg[7*i +: 7] = BL;
                else
                    e_seg[7*i +: 7] = glyph(m_card[i]);
                if (m_card[i] >= 1 && m_card[i] <= 9) sum += m_card[i];
            end
            e_score = digit(sum % 10);
            valid = bus.load_en && (int'(bus.load_slot) < NS);
            if (bus.clear) begin
                for (int i = 0; i < NS; i++) m_card[i] = 0;
                m_act = 0;
            end else begin
                if (valid) m_card[bus.load_slot] = int'(bus.load_card);
                if (valid && bus.blink_en) begin
                    m_act = 1; m_slot = int'(bus.load_slot); m_el = 0;
                end else if (m_act) begin
                    m_el++;
                    if (m_el >= 2 * H * C) m_act = 0;
                end
            end
        end
        for (int i = 0; i < NS; i++) e_card[4*i +: 4] = 4'(m_card[i]);
        e_busy = m_act;
    end

    always @(negedge slow_clock) begin
        if (mon_on) begin
            chk("card_out", 64'(card_out), 64'(e_card));
            chk("seg7_out", 64'(seg7_out), 64'(e_seg));
            chk("score_seg7", 64'(score_seg7), 64'(e_score));
            chk("busy", 64'(busy), 64'(e_busy));
        end
    end

    task automatic load(input int slot, input int card, input bit blink);
        bus.load_en   = 1'b1;
        bus.load_slot = 3'(slot);
        bus.load_card = 4'(card);
        bus.blink_en  = blink;
        @(negedge slow_clock);
    endtask

    task automatic idle(input int n);
        bus.load_en  = 1'b0;
        bus.blink_en = 1'b0;
        repeat (n) @(negedge slow_clock);
    endtask

    function automatic logic [6:0] seg_of(input int i);
        return seg7_out[7*i +: 7];
    endfunction

    initial begin
        int bcnt;
        logic [8:0] pat;
        resetb = 1'b0;
        bus.clear = 1'b0; bus.load_en = 1'b0; bus.load_slot = '0;
        bus.load_card = '0; bus.blink_en = 1'b0;
        @(negedge slow_clock);
        mon_on = 1;
        @(negedge slow_clock);
        resetb = 1'b1;
        idle(3);
        // 1: reset state
        chk("rst_card", 64'(card_out), 64'h0);
        chk("rst_seg", 64'(seg7_out), 64'({NS{BL}}));
        chk("rst_score", 64'(score_seg7), 64'(7'b1000000));
        chk("rst_busy", 64'(busy), 64'h0);

        // 2: steady loads, score 7+8+0 = 5
        load(0, 7, 0); load(1, 8, 0); load(2, 13, 0);
        idle(1);
        chk("t2_seg0", 64'(seg_of(0)), 64'(7'b1111000));
        chk("t2_seg1", 64'(seg_of(1)), 64'(7'b0000000));
        chk("t2_seg2", 64'(seg_of(2)), 64'(7'b0001001));
        chk("t2_score", 64'(score_seg7), 64'(7'b0010010));

        // 3: blink slot3 with an ace
        load(3, 1, 1);
        bus.load_en = 1'b0; bus.blink_en = 1'b0;
        bcnt = 0; pat = '0;
        for (int j = 0; j < 10; j++) begin
            if (busy) bcnt++;
            if (j >= 1) pat[j-1] = (seg_of(3) == BL);
            @(negedge slow_clock);
        end
        chk("t3_busy_cycles", 64'(bcnt), 64'd8);
        chk("t3_blink_pattern", 64'(pat), 64'(9'b000110011));
        chk("t3_seg3_final", 64'(seg_of(3)), 64'(7'b0001000));

        // 4: restart blink on slot4 while slot3 is blanked
        load(3, 1, 1);
        idle(1);
        chk("t4_seg3_off", 64'(seg_of(3)), 64'(BL));
        load(4, 5, 1);
        bus.load_en = 1'b0; bus.blink_en = 1'b0;
        bcnt = 0;
        for (int j = 0; j < 10; j++) begin
            if (busy) bcnt++;
            if (j == 1) begin
                chk("t4_seg3_steady", 64'(seg_of(3)), 64'(7'b0001000));
                chk("t4_seg4_off", 64'(seg_of(4)), 64'(BL));
            end
            @(negedge slow_clock);
        end
        chk("t4_busy_cycles", 64'(bcnt), 64'd8);
        // score 7+8+0+1+5 = 21 -> 1
        chk("t4_score", 64'(score_seg7), 64'(7'b1111001));

        // 5: clear with load mid-blink
        load(5, 9, 1);
        idle(2);
        bus.clear = 1'b1;
        load(0, 3, 1);
        bus.clear = 1'b0;
        chk("t5_card", 64'(card_out), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        idle(1);
        chk("t5_seg", 64'(seg7_out), 64'({NS{BL}}));
        chk("t5_score", 64'(score_seg7), 64'(7'b1000000));

        // 6: out-of-range slot ignored, then reset mid-blink
        load(1, 2, 0);
        idle(2);
        load(7, 5, 1);
        idle(3);
        chk("t6_card", 64'(card_out), 64'h000020);
        chk("t6_seg1", 64'(seg_of(1)), 64'(7'b0100100));
        chk("t6_busy", 64'(busy), 64'h0);
        load(2, 6, 1);
        idle(1);
        resetb = 1'b0;
        @(negedge slow_clock);
        chk("t6_rst_card", 64'(card_out), 64'h0);
        chk("t6_rst_seg", 64'(seg7_out), 64'({NS{BL}}));
        chk("t6_rst_score", 64'(score_seg7), 64'(7'b1000000));
        chk("t6_rst_busy", 64'(busy), 64'h0);
        resetb = 1'b1;
        idle(2);
        mon_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/card_display_bank.md
Name: card_display_bank

Overview:
Parametrised successor to the single-card 7-segment decoder. Stores up to N_SLOTS dealt cards and drives one 7-segment digit per slot. Blinks the most recently dealt slot for a fixed number of periods. Drives an extra digit showing the Baccarat hand score (sum of card values mod 10). Sits between the dealer datapath (card loads) and the board HEX displays.

Parameters:
N_SLOTS, 6, number of card slots/digits (1..8)
BLINK_HALF, 8, cycles per blink half-period (>=1)
BLINK_COUNT, 3, full off/on periods per blink sequence (>=1)

Ports:
slow_clock  input  1  clock; all state updates on rising edge
resetb  input  1  synchronous, active-low reset
clear  input  1  empty all slots, abort blink
load_en  input  1  write load_card into slot load_slot
load_slot  input  $clog2(N_SLOTS) (min 1)  target slot index
load_card  input  4  card code: 1=A, 2..10, 11=J, 12=Q, 13=K; 0/14/15 = empty
blink_en  input  1  sampled with load_en; 1 = blink the loaded slot
card_out  output  N_SLOTS*4  stored card codes, slot i at [4i+3:4i]
seg7_out  output  N_SLOTS*7  active-low segments, slot i at [7i+6:7i]
score_seg7  output  7  active-low digit 0..9 of hand score
busy  output  1  blink sequence in progress

Behaviour:
- Reset (resetb=0 at an edge): all slots 0, card_out=0, every seg7_out slot = BLANK 1111111, score_seg7 = digit "0" 1000000, busy=0, FSM IDLE.
- Priority per edge: resetb, then clear, then load_en. clear with load_en: the load is dropped.
- Load: load_en=1 and load_slot<N_SLOTS writes the slot. card_out updates on that edge (k). load_slot>=N_SLOTS is ignored, with no state change and no blink.
- Card glyphs are unchanged from the existing decoder:
  A 0001000, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, 10 1000000, J 1100001, Q 0011000, K 1001001? No: K 0001001. Other codes show BLANK.
- seg7_out and score_seg7 are registered from slot/FSM state. One cycle latency: a load at edge k is visible after edge k+1.
- Score: value(c) = c for 1..9, 0 otherwise. score = (sum over slots of value) mod 10, reduced with a modulo-10 accumulate (no overflow for N_SLOTS<=8).
- Score digit glyphs: 0 1000000, 1 1111001; 2..9 use the card 2..9 patterns.
- Blink FSM states: IDLE, OFF, ON. An internal half counter counts 0..BLINK_HALF-1. A period counter counts 0..BLINK_COUNT-1.
  - IDLE -> OFF on a valid load with blink_en=1. Captures blink_slot and zeroes both counters.
  - OFF -> ON when half counter = BLINK_HALF-1.
  - ON -> OFF when half counter = BLINK_HALF-1 and period counter < BLINK_COUNT-1. The period counter increments.
  - ON -> IDLE when half counter = BLINK_HALF-1 and period counter = BLINK_COUNT-1.
  - A valid blinking load in OFF/ON restarts the sequence on the new slot. The old slot reverts to steady display.
  - A valid load with blink_en=0 during a blink updates that slot and does not disturb the sequence.
  - clear in any state -> IDLE.
- While in OFF, slot blink_slot shows BLANK (one cycle later, per the output latency). In IDLE/ON it shows its glyph. The score digit never blinks.
- busy = (state != IDLE), combinational from state. It is high for exactly 2*BLINK_HALF*BLINK_COUNT cycles after the loading edge.
- Reset mid-blink: returns to the full reset values above at that edge.

Decomposition:
- Package card_disp_pkg holds:
  - card code constants and card_t (logic [3:0])
  - segment pattern constants (cards, digits 0..9, BLANK)
  - card_to_seg, card_value, digit_to_seg functions
  - blink_state_t enum {IDLE, OFF, ON}
- Sub-module card_blink_fsm holds the FSM, both counters, blink_slot and busy. It outputs blank_mask[N_SLOTS-1:0].
- Top holds the slot registers, score adder and output registers.

Test Plan:
All tests use N_SLOTS=6, BLINK_HALF=2, BLINK_COUNT=2.
1. Reset then idle 3 cycles -> card_out=0, all seg7_out slots 1111111, score_seg7=1000000, busy=0.
2. Load slot0=7, slot1=8, slot2=13 with blink_en=0 on consecutive cycles -> one cycle after the last load, slot glyphs are 1111000/0000000/0001001 and score_seg7 = 5 (0010010).
3. Load slot3=1 with blink_en=1 -> busy high 8 cycles. Slot3 seg shows 1111111 for 2 cycles, then 0001000 for 2, then 1111111 for 2, then 0001000 steady. Other slots steady.
4. Blinking load on slot4 mid-blink of slot3 -> slot3 steady immediately (next cycle). busy stays high 8 cycles from the new load.
5. clear and load_en together mid-blink -> all slots empty and BLANK, score 1000000, busy=0 next cycle, load ignored.
6. load_slot=7 (>=N_SLOTS), load_en=1, blink_en=1 -> no change to any output, busy stays 0. resetb=0 during a blink -> reset values at that edge.
